wallace_mul12_sequencer: RTL
============================

Name: wallace_mul12_sequencer

Overview:
Iterative controller that computes a 12x12 unsigned product by time-multiplexing one external 6x6 Wallace-tree multiplier over four passes. It splits each operand into 6-bit halves, drives the multiplier's operand inputs, and shift-accumulates the 12-bit partial products into a 24-bit result. Upstream and downstream connect through valid/ready handshakes. The block sits between the operand source and the 6x6 combinational multiplier instance.

Parameters:
MUL_LAT, 0, number of register stages on the multiplier result path before accumulation. Legal values are 0 and 1. With 1, mul_p is registered internally before the add.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept an operand pair
in_a  input  12  multiplicand, unsigned
in_b  input  12  multiplier, unsigned
out_valid  output  1  product valid
out_ready  input  1  downstream accepts the product
out_p  output  24  product in_a*in_b, unsigned
mul_a  output  6  operand A to the 6x6 multiplier
mul_b  output  6  operand B to the 6x6 multiplier
mul_p  input  12  product returned by the 6x6 multiplier; combinational from mul_a/mul_b
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, pass=0, acc=0.
  - out_p=0, out_valid=0, in_ready=0 while reset is asserted, then 1 in IDLE.
  - mul_a=0, mul_b=0, busy=0.
  - Reset mid-operation discards the in-flight operation; no output is produced for it.
- States: IDLE, MUL, DRAIN (present only when MUL_LAT=1), DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_a/in_b into op registers, clear acc, set pass=0, go to MUL.
  - in_a/in_b are ignored when in_valid=0.
- MUL:
  - pass is a 2-bit counter.
  - Multiplier operands are registered outputs, driven from the op registers and pass:
    - pass0: aL,bL with shift 0
    - pass1: aH,bL with shift 6
    - pass2: aL,bH with shift 6
    - pass3: aH,bH with shift 12
    - aL=op_a[5:0], aH=op_a[11:6]; bL and bH are split the same way.
  - MUL_LAT=0: each cycle, acc <= acc + (mul_p << shift(pass)). After pass3, go to DONE.
  - MUL_LAT=1: mul_p is captured into p_q together with the shift tag. acc adds p_q one cycle later. After pass3, go to DRAIN for one cycle to add the final term, then go to DONE.
- Accumulator:
  - 24 bits wide; each term is zero-extended.
  - Overflow is impossible: max 4095*4095 = 0xFFE001 < 2^24.
  - No wrap handling is required; an assertion fires if the sum carries out of bit 23.
- DONE:
  - out_valid=1 and out_p=acc.
  - Both hold stable until out_ready=1.
  - On out_valid&out_ready: go to IDLE and drop out_valid in the next cycle.
  - in_ready=0 in DONE; there is no same-cycle turnaround.
- Latency (acceptance edge to out_valid high): 4 cycles for MUL_LAT=0, 5 cycles for MUL_LAT=1.
- Throughput: one product per latency+2 cycles with out_ready held at 1.
- in_ready is 0 in MUL/DRAIN/DONE. in_valid asserted during those states is ignored, and the source must hold its data.
- mul_a/mul_b return to 0 in IDLE and DONE, so the multiplier input does not toggle when idle.
- out_p holds the last product after it is consumed, until the next DONE updates it.
- busy = (state != IDLE).

Test Plan:
- Basic product, MUL_LAT=0, out_ready=1: in_a=0x0AB, in_b=0x0CD -> out_p=0x0088EF (35055). out_valid rises exactly 4 cycles after the handshake.
- Maximum operands: in_a=0xFFF, in_b=0xFFF -> out_p=0xFFE001, no overflow assertion. Repeat with MUL_LAT=1 -> same value, latency 5.
- Zero and cross-half operands:
  - in_a=0x800, in_b=0x002 -> 0x001000.
  - in_a=0, in_b=0xFFF -> 0.
  - Check mul_a/mul_b follow the pass order L·L, H·L, L·H, H·H.
- Backpressure: hold out_ready=0 for 10 cycles after DONE. Required: out_valid and out_p stable, in_ready=0, and a second in_valid is not accepted. Release out_ready -> one transfer, then in_ready=1 in the next cycle.
- Reset mid-operation: assert rst_n=0 during pass2 of 0x123*0x456. Required: all outputs go to their reset values immediately, and no out_valid appears. A new operation after reset, 0x123*0x456, gives 0x04EDC2.
- Back-to-back stream: 100 random pairs with in_valid always high and random out_ready. Compare every result against a reference model; the count of outputs equals the count of inputs.

Source files
------------

// File: rtl/wallace_mul12_sequencer.sv
// 12x12 unsigned multiplier sequencer: reuses one external 6x6 multiplier over four passes
// and shift-accumulates the partial products into a 24-bit result.
module wallace_mul12_sequencer #(
  parameter int MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_a,
  input  logic [11:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_p,
  output logic [5:0]  mul_a,
  output logic [5:0]  mul_b,
  input  logic [11:0] mul_p,
  output logic        busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid and its data stay stable until that edge, and ready never depends on valid.

  typedef enum logic [1:0] {IDLE, MUL, DRAIN, DONE} state_t;

  state_t      state;
  logic [11:0] op_a;
  logic [11:0] op_b;
  logic [1:0]  pass;
  logic [23:0] acc;
  logic [11:0] p_q;
  logic [1:0]  p_tag;
  logic        p_vld;

  logic [11:0] add_p;
  logic [1:0]  add_tag;
  logic        add_en;
  logic [23:0] term;
  logic [24:0] sum;

  // Operand halves for a pass, packed as {mul_a, mul_b}: LL, HL, LH, HH.
  function automatic logic [11:0] pass_ops(input logic [1:0] p, input logic [11:0] a,
                                           input logic [11:0] b);
    logic [11:0] r;
    case (p)
      2'd0:    r = {a[5:0],  b[5:0]};
      2'd1:    r = {a[11:6], b[5:0]};
      2'd2:    r = {a[5:0],  b[11:6]};
      default: r = {a[11:6], b[11:6]};
    endcase
    return r;
  endfunction

  // The term added this cycle comes straight from the multiplier, or from p_q one cycle later.
  always_comb begin
    add_p   = mul_p;
    add_tag = pass;
    add_en  = (state == MUL);
    if (MUL_LAT != 0) begin
      add_p   = p_q;
      add_tag = p_tag;
      add_en  = p_vld;
    end
    case (add_tag)
      2'd0:       term = {12'd0, add_p};
      2'd1, 2'd2: term = {6'd0, add_p, 6'd0};
      default:    term = {add_p, 12'd0};
    endcase
    sum = {1'b0, acc} + {1'b0, term};
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      pass      <= '0;
      acc       <= '0;
      p_q       <= '0;
      p_tag     <= '0;
      p_vld     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_p     <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      if (MUL_LAT != 0) begin
        p_q   <= mul_p;
        p_tag <= pass;
        p_vld <= (state == MUL);
      end
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            op_a           <= in_a;
            op_b           <= in_b;
            acc            <= '0;
            pass           <= 2'd0;
            {mul_a, mul_b} <= pass_ops(2'd0, in_a, in_b);
            in_ready       <= 1'b0;
            state          <= MUL;
          end
        end
        MUL: begin
          if (add_en) acc <= sum[23:0];
          pass <= pass + 2'd1;
          if (pass == 2'd3) begin
            mul_a <= '0;
            mul_b <= '0;
            if (MUL_LAT == 0) begin
              out_p     <= sum[23:0];
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= DRAIN;
            end
          end else begin
            {mul_a, mul_b} <= pass_ops(pass + 2'd1, op_a, op_b);
          end
        end
        DRAIN: begin
          acc       <= sum[23:0];
          out_p     <= sum[23:0];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A 12x12 product always fits in 24 bits; a carry out means corrupted state.
  acc_no_carry: assert property (@(posedge clk) disable iff (!rst_n) !(add_en && sum[24]));

endmodule
